bus_endpoint_fifo: RTL and testbench

BUS_ENDPOINT_FIFO -- requirements
Module: bus_endpoint_fifo

---
 rtl/bus_endpoint_fifo.sv | 127 ++++++++++++
 tb/tb_bus_endpoint_fifo.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/bus_endpoint_fifo.sv
// Bus endpoint: host-to-bus TX FIFO and bus-to-host RX FIFO with an
// address filter on the RX side, sticky error flags and a drop counter.
module bus_endpoint_fifo #(
   parameter int unsigned pckg_sz    = 16,
   parameter int unsigned fifo_depth = 16,
   parameter logic [7:0]  id         = 8'h00,
   parameter logic [7:0]  broadcast  = 8'hFF
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          wr_en,
   input  logic [pckg_sz-1:0]            wr_data,
   output logic                          tx_full,
   output logic [$clog2(fifo_depth):0]   tx_count,
   input  logic                          rd_en,
   output logic [pckg_sz-1:0]            rd_data,
   output logic                          rx_empty,
   output logic [$clog2(fifo_depth):0]   rx_count,
   output logic                          pndng,
   output logic [pckg_sz-1:0]            D_pop,
   input  logic                          pop,
   input  logic                          push,
   input  logic [pckg_sz-1:0]            D_push,
   input  logic                          clr_err,
   output logic                          tx_ovf,
   output logic                          tx_udf,
   output logic                          rx_ovf,
   output logic [7:0]                    drop_cnt
);

   localparam int unsigned AW = $clog2(fifo_depth);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(fifo_depth);

   logic [pckg_sz-1:0] tx_mem_q [fifo_depth];
   logic [pckg_sz-1:0] rx_mem_q [fifo_depth];

   logic [AW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
   logic [AW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
   logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
   logic          tx_ovf_q, tx_ovf_d, tx_udf_q, tx_udf_d;
   logic          rx_ovf_q, rx_ovf_d;
   logic [7:0]    drop_q, drop_d;

   logic       tx_we, tx_re, rx_we, rx_re;
   logic       accept, drop, ovf_tx_ev, udf_tx_ev, ovf_rx_ev;
   logic [7:0] dest;

   assign dest     = D_push[pckg_sz-1 -: 8];
   assign accept   = (dest == id) || (dest == broadcast);

   assign pndng    = (tx_cnt_q != '0);
   assign tx_full  = (tx_cnt_q == FULL);
   assign rx_empty = (rx_cnt_q == '0);
   assign tx_count = tx_cnt_q;
   assign rx_count = rx_cnt_q;
   assign D_pop    = pndng ? tx_mem_q[tx_rp_q] : '0;
   assign rd_data  = rx_empty ? '0 : rx_mem_q[rx_rp_q];
   assign tx_ovf   = tx_ovf_q;
   assign tx_udf   = tx_udf_q;
   assign rx_ovf   = rx_ovf_q;
   assign drop_cnt = drop_q;

   always_comb begin
      tx_re     = pop && pndng;
      tx_we     = wr_en && (!tx_full || tx_re);
      ovf_tx_ev = wr_en && tx_full && !pop;
      udf_tx_ev = pop && !pndng;
      rx_re     = rd_en && !rx_empty;
      rx_we     = push && accept && (!(rx_cnt_q == FULL) || rx_re);
      ovf_rx_ev = push && accept && (rx_cnt_q == FULL) && !rd_en;
      drop      = push && !accept;

      tx_wp_d  = tx_wp_q + AW'(tx_we);
      tx_rp_d  = tx_rp_q + AW'(tx_re);
      tx_cnt_d = tx_cnt_q + CW'(tx_we) - CW'(tx_re);
      rx_wp_d  = rx_wp_q + AW'(rx_we);
      rx_rp_d  = rx_rp_q + AW'(rx_re);
      rx_cnt_d = rx_cnt_q + CW'(rx_we) - CW'(rx_re);

      // A coincident event wins over clr_err.
      tx_ovf_d = ovf_tx_ev || (tx_ovf_q && !clr_err);
      tx_udf_d = udf_tx_ev || (tx_udf_q && !clr_err);
      rx_ovf_d = ovf_rx_ev || (rx_ovf_q && !clr_err);

      drop_d = drop_q;
      if (clr_err)
         drop_d = {7'b0, drop};
      else if (drop && drop_q != 8'hFF)
         drop_d = drop_q + 8'd1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_wp_q  <= '0;
         tx_rp_q  <= '0;
         tx_cnt_q <= '0;
         rx_wp_q  <= '0;
         rx_rp_q  <= '0;
         rx_cnt_q <= '0;
         tx_ovf_q <= 1'b0;
         tx_udf_q <= 1'b0;
         rx_ovf_q <= 1'b0;
         drop_q   <= '0;
      end else begin
         tx_wp_q  <= tx_wp_d;
         tx_rp_q  <= tx_rp_d;
         tx_cnt_q <= tx_cnt_d;
         rx_wp_q  <= rx_wp_d;
         rx_rp_q  <= rx_rp_d;
         rx_cnt_q <= rx_cnt_d;
         tx_ovf_q <= tx_ovf_d;
         tx_udf_q <= tx_udf_d;
         rx_ovf_q <= rx_ovf_d;
         drop_q   <= drop_d;
      end
   end

   // Storage has no reset; it is masked by the counts while empty.
   always_ff @(posedge clk) begin
      if (tx_we)
         tx_mem_q[tx_wp_q] <= wr_data;
      if (rx_we)
         rx_mem_q[rx_wp_q] <= D_push;
   end

endmodule

// File: tb/tb_bus_endpoint_fifo.sv
// Scoreboard bench for bus_endpoint_fifo: stimulus queues expected
// packets, a negedge monitor checks every TX pop and RX read.
module tb_bus_endpoint_fifo;

   logic        clk = 1'b0;
   logic        reset;
   logic        wr_en, rd_en, pop, push, clr_err;
   logic [15:0] wr_data, D_push;
   logic        tx_full, rx_empty, pndng;
   logic [4:0]  tx_count, rx_count;
   logic [15:0] rd_data, D_pop;
   logic        tx_ovf, tx_udf, rx_ovf;
   logic [7:0]  drop_cnt;

   int checks = 0;
   int errors = 0;
   logic [15:0] tx_q[$];
   logic [15:0] rx_q[$];

   always #5 clk = ~clk;

   bus_endpoint_fifo #(
      .pckg_sz(16), .fifo_depth(16), .id(8'h02), .broadcast(8'hFF)
   ) dut (
      .clk(clk), .reset(reset),
      .wr_en(wr_en), .wr_data(wr_data),
      .tx_full(tx_full), .tx_count(tx_count),
      .rd_en(rd_en), .rd_data(rd_data),
      .rx_empty(rx_empty), .rx_count(rx_count),
      .pndng(pndng), .D_pop(D_pop), .pop(pop),
      .push(push), .D_push(D_push), .clr_err(clr_err),
      .tx_ovf(tx_ovf), .tx_udf(tx_udf), .rx_ovf(rx_ovf),
      .drop_cnt(drop_cnt)
   );

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Monitor: the DUT presents a packet whenever a consuming strobe
   // meets a non-empty FIFO.
   always @(negedge clk) begin
      if (reset && pop && pndng) begin
         if (tx_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL tx_unexpected: got %0h expected none", D_pop);
         end else
            chk("tx_pop_data", {16'h0, D_pop}, {16'h0, tx_q.pop_front()});
      end
      if (reset && rd_en && !rx_empty) begin
         if (rx_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL rx_unexpected: got %0h expected none", rd_data);
         end else
            chk("rx_rd_data", {16'h0, rd_data}, {16'h0, rx_q.pop_front()});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      wr_en = 0; pop = 0; push = 0; rd_en = 0; clr_err = 0;
   endtask

   task automatic host_wr(logic [15:0] d);
      wr_en = 1; wr_data = d; tx_q.push_back(d); tick();
   endtask

   task automatic bus_push(logic [15:0] d, bit exp_acc);
      push = 1; D_push = d;
      if (exp_acc) rx_q.push_back(d);
      tick();
   endtask

   task automatic bus_pop();
      pop = 1; tick();
   endtask

   task automatic host_rd();
      rd_en = 1; tick();
   endtask

   initial begin
      wr_en = 0; rd_en = 0; pop = 0; push = 0; clr_err = 0;
      wr_data = 0; D_push = 0;
      reset = 0;
      #2;
      chk("rst_tx_count", 32'(tx_count), 0);
      chk("rst_rx_count", 32'(rx_count), 0);
      chk("rst_pndng", 32'(pndng), 0);
      chk("rst_D_pop", 32'(D_pop), 0);
      chk("rst_rd_data", 32'(rd_data), 0);
      chk("rst_rx_empty", 32'(rx_empty), 1);
      chk("rst_tx_full", 32'(tx_full), 0);
      chk("rst_flags", {29'h0, tx_ovf, tx_udf, rx_ovf}, 0);
      chk("rst_drop", 32'(drop_cnt), 0);
      @(negedge clk);
      reset = 1;
      @(posedge clk);
      #1;

      // TX basic
      host_wr(16'h0311);
      host_wr(16'h0322);
      chk("tx_pndng", 32'(pndng), 1);
      chk("tx_head", 32'(D_pop), 32'h0311);
      bus_pop();
      chk("tx_head2", 32'(D_pop), 32'h0322);
      bus_pop();
      chk("tx_pndng_end", 32'(pndng), 0);
      chk("tx_dpop_zero", 32'(D_pop), 0);
      chk("tx_noflags", {29'h0, tx_ovf, tx_udf, rx_ovf}, 0);

      // RX filter
      bus_push(16'h0255, 1);
      bus_push(16'hFF66, 1);
      bus_push(16'h0377, 0);
      chk("rx_count2", 32'(rx_count), 2);
      chk("rx_head", 32'(rd_data), 32'h0255);
      chk("rx_drop1", 32'(drop_cnt), 1);
      host_rd();
      host_rd();
      chk("rx_empty_end", 32'(rx_empty), 1);
      chk("rx_rdata_zero", 32'(rd_data), 0);
      host_rd();
      chk("rx_rd_empty_noflag", {29'h0, tx_ovf, tx_udf, rx_ovf}, 0);

      // TX full behaviour
      for (int i = 0; i < 16; i++) host_wr(16'h0100 + 16'(i));
      chk("tx_full", 32'(tx_full), 1);
      chk("tx_count16", 32'(tx_count), 16);
      wr_en = 1; wr_data = 16'h0CAF; pop = 1;
      tx_q.push_back(16'h0CAF);
      tick();
      chk("tx_wrpop_count", 32'(tx_count), 16);
      chk("tx_wrpop_noflag", 32'(tx_ovf), 0);
      wr_en = 1; wr_data = 16'hBEEF;
      tick();
      chk("tx_ovf", 32'(tx_ovf), 1);
      chk("tx_ovf_count", 32'(tx_count), 16);
      for (int i = 0; i < 16; i++) bus_pop();
      chk("tx_drained", 32'(pndng), 0);

      // RX full behaviour
      for (int i = 0; i < 16; i++) bus_push(16'h0200 + 16'(i), 1);
      chk("rx_count16", 32'(rx_count), 16);
      bus_push(16'h02AA, 0);
      chk("rx_ovf", 32'(rx_ovf), 1);
      chk("rx_ovf_count", 32'(rx_count), 16);
      push = 1; D_push = 16'h02BB; rd_en = 1;
      rx_q.push_back(16'h02BB);
      tick();
      chk("rx_pushrd_count", 32'(rx_count), 16);
      bus_pop();
      chk("tx_udf", 32'(tx_udf), 1);
      clr_err = 1;
      tick();
      chk("clr_flags", {29'h0, tx_ovf, tx_udf, rx_ovf}, 0);
      chk("clr_drop", 32'(drop_cnt), 0);
      for (int i = 0; i < 16; i++) host_rd();
      chk("rx_drained", 32'(rx_empty), 1);

      // Drop counter saturation and clr priority
      for (int i = 0; i < 300; i++) bus_push(16'h0500 + 16'(i % 256), 0);
      chk("drop_sat", 32'(drop_cnt), 255);
      chk("drop_rx_empty", 32'(rx_empty), 1);
      clr_err = 1; push = 1; D_push = 16'h0599;
      tick();
      chk("drop_clr_prio", 32'(drop_cnt), 1);
      clr_err = 1; pop = 1;
      tick();
      chk("udf_clr_prio", 32'(tx_udf), 1);
      clr_err = 1;
      tick();

      // Async reset mid-transfer
      for (int i = 0; i < 5; i++) host_wr(16'h0700 + 16'(i));
      for (int i = 0; i < 5; i++) bus_push(16'h0280 + 16'(i), 1);
      chk("pre_rst_tx", 32'(tx_count), 5);
      chk("pre_rst_rx", 32'(rx_count), 5);
      #2;
      reset = 0;
      #1;
      chk("arst_tx_count", 32'(tx_count), 0);
      chk("arst_rx_count", 32'(rx_count), 0);
      chk("arst_pndng", 32'(pndng), 0);
      chk("arst_rx_empty", 32'(rx_empty), 1);
      tx_q.delete();
      rx_q.delete();
      @(negedge clk);
      reset = 1;
      host_wr(16'h0A0A);
      chk("first_wr", 32'(tx_count), 1);
      chk("first_wr_head", 32'(D_pop), 32'h0A0A);

      // All four strobes together
      bus_push(16'h02C1, 1);
      wr_en = 1; wr_data = 16'h0B0B; tx_q.push_back(16'h0B0B);
      pop = 1;
      push = 1; D_push = 16'h02C2; rx_q.push_back(16'h02C2);
      rd_en = 1;
      tick();
      chk("conc_tx_count", 32'(tx_count), 1);
      chk("conc_rx_count", 32'(rx_count), 1);
      bus_pop();
      host_rd();
      chk("tx_q_left", 32'(tx_q.size()), 0);
      chk("rx_q_left", 32'(rx_q.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
